// File: rtl/pio_button_pkg.sv
// Shared definitions for the pushbutton PIO service controller: PIO register
// map, service FSM encoding and the event record layout.
package pio_button_pkg;

   localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
   localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

   localparam int EVT_STAMP_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_MASK,
      ST_WAIT_IRQ,
      ST_RD_CAP,
      ST_RD_WAIT,
      ST_CLR,
      ST_PUSH,
      ST_WR_OFF
   } svc_state_e;

   typedef struct packed {
      logic [EVT_STAMP_W-1:0] stamp;
      logic [3:0]             buttons;
   } pio_evt_t;

endpackage

// File: rtl/pio_button_service_ctrl_if.sv
// Avalon-MM link between the service controller (master) and the pushbutton
// PIO (slave), plus the PIO level interrupt.
interface pio_button_service_ctrl_if;
   import pio_button_pkg::*;

   logic [1:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [31:0] m_writedata;
   logic [31:0] m_readdata;
   logic        pio_irq;

   modport master (
      output m_address, m_chipselect, m_write_n, m_writedata,
      input  m_readdata, pio_irq
   );

   modport slave (
      input  m_address, m_chipselect, m_write_n, m_writedata,
      output m_readdata, pio_irq
   );

endinterface

// File: rtl/pio_evt_fifo.sv
// Synchronous event FIFO. Head data and flags come straight from flops, so a
// push into an empty FIFO becomes visible on the following cycle.
module pio_evt_fifo
   import pio_button_pkg::*;
#(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   // A full FIFO still takes a push when the head leaves in the same cycle.
   always_comb begin
      do_pop   = pop && (cnt_q != '0);
      do_push  = push && ((cnt_q != CNT_FULL) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
         cnt_d = cnt_q - (AW+1)'(1);
      end
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign full      = (cnt_q == CNT_FULL);
   assign empty     = (cnt_q == '0);

endmodule

// File: rtl/pio_button_service_ctrl.sv
// Pushbutton PIO service master: keeps the PIO irq mask in step with cfg_mask,
// services edge-capture interrupts, applies per-button hold-off and queues
// timestamped button events.
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_IDLE     | service disabled, bus idle
// ST_WR_MASK  | write cfg_mask to PIO mask register
// ST_WAIT_IRQ | armed, waiting for PIO irq / config change
// ST_RD_CAP   | read strobe on edge-capture register
// ST_RD_WAIT  | capture read data
// ST_CLR      | write-1-clear the captured bits
// ST_PUSH     | filter through hold-off, enqueue event
// ST_WR_OFF   | write 0 to PIO mask register, then idle
module pio_button_service_ctrl
   import pio_button_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int HOLDOFF = 50000,
   parameter int STAMP_W = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      cfg_enable,
   input  logic [3:0]                cfg_mask,
   pio_button_service_ctrl_if.master bus,
   output logic                      evt_valid,
   input  logic                      evt_ready,
   output logic [STAMP_W+3:0]        evt_data,
   output logic                      ovf,
   input  logic                      ovf_clr
);

   localparam int HW = $clog2(HOLDOFF + 2);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

   svc_state_e       state_q, state_d;
   logic [3:0]       mask_shadow_q, mask_shadow_d;
   logic [3:0]       cap_q, cap_d;
   logic [HW-1:0]    hold_q [4];
   logic [HW-1:0]    hold_d [4];
   logic [STAMP_W-1:0] stamp_q, stamp_d;
   logic             ovf_q, ovf_d;
   logic [3:0]       holding;
   logic [3:0]       rep;
   logic             evt_push, evt_pop;
   logic             fifo_full, fifo_empty;
   logic             unused_rd;

   assign unused_rd = ^bus.m_readdata[31:4];

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; enable is only looked at while armed so a started
   // service always runs to completion.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (cfg_enable) state_d = ST_WR_MASK;
         ST_WR_MASK:  state_d = ST_WAIT_IRQ;
         ST_WAIT_IRQ: begin
            if (!cfg_enable)                    state_d = ST_WR_OFF;
            else if (cfg_mask != mask_shadow_q) state_d = ST_WR_MASK;
            else if (bus.pio_irq)               state_d = ST_RD_CAP;
         end
         ST_RD_CAP:   state_d = ST_RD_WAIT;
         ST_RD_WAIT:  state_d = ST_CLR;
         ST_CLR:      state_d = ST_PUSH;
         ST_PUSH:     state_d = ST_WAIT_IRQ;
         ST_WR_OFF:   state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Bus outputs decoded from the state register.
   always_comb begin
      bus.m_chipselect = 1'b0;
      bus.m_write_n    = 1'b1;
      bus.m_address    = PIO_ADDR_DATA;
      bus.m_writedata  = '0;
      case (state_q)
         ST_WR_MASK: begin
            bus.m_chipselect = 1'b1;
            bus.m_write_n    = 1'b0;
            bus.m_address    = PIO_ADDR_MASK;
            bus.m_writedata  = {28'd0, cfg_mask};
         end
         ST_RD_CAP: begin
            bus.m_chipselect = 1'b1;
            bus.m_address    = PIO_ADDR_EDGE;
         end
         ST_CLR: begin
            bus.m_chipselect = 1'b1;
            bus.m_write_n    = 1'b0;
            bus.m_address    = PIO_ADDR_EDGE;
            bus.m_writedata  = {28'd0, cap_q};
         end
         ST_WR_OFF: begin
            bus.m_chipselect = 1'b1;
            bus.m_write_n    = 1'b0;
            bus.m_address    = PIO_ADDR_MASK;
         end
         default: ;
      endcase
   end

   // Datapath: mask shadow, capture, hold-off timers, stamp, overflow.
   // A drop only happens when the FIFO is full and not draining this cycle.
   always_comb begin
      for (int i = 0; i < 4; i++) holding[i] = (hold_q[i] != '0);
      rep           = cap_q & ~holding;
      mask_shadow_d = mask_shadow_q;
      cap_d         = cap_q;
      stamp_d       = stamp_q + STAMP_W'(1);
      ovf_d         = ovf_clr ? 1'b0 : ovf_q;
      evt_push      = 1'b0;
      for (int i = 0; i < 4; i++) begin
         hold_d[i] = holding[i] ? hold_q[i] - HW'(1) : hold_q[i];
      end
      case (state_q)
         ST_WR_MASK: mask_shadow_d = cfg_mask;
         ST_WR_OFF:  mask_shadow_d = 4'd0;
         ST_RD_WAIT: cap_d = bus.m_readdata[3:0];
         ST_PUSH: begin
            if (rep != 4'd0) begin
               if (fifo_full && !evt_pop) ovf_d = 1'b1;
               else                       evt_push = 1'b1;
               for (int i = 0; i < 4; i++) begin
                  if (rep[i]) hold_d[i] = HOLD_LOAD;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_shadow_q <= '0;
         cap_q         <= '0;
         for (int i = 0; i < 4; i++) hold_q[i] <= '0;
         stamp_q       <= '0;
         ovf_q         <= 1'b0;
      end else begin
         mask_shadow_q <= mask_shadow_d;
         cap_q         <= cap_d;
         hold_q        <= hold_d;
         stamp_q       <= stamp_d;
         ovf_q         <= ovf_d;
      end
   end

   assign evt_valid = !fifo_empty;
   assign evt_pop   = evt_valid && evt_ready;
   assign ovf       = ovf_q;

   pio_evt_fifo #(
      .WIDTH (STAMP_W + 4),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (evt_push),
      .push_data ({stamp_q, rep}),
      .pop       (evt_pop),
      .head_data (evt_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: doc/pio_button_service_ctrl.md
# pio_button_service_ctrl

Avalon-MM master controller that owns the 4-bit pushbutton PIO slave: it programs the PIO interrupt mask, services the PIO `irq` by reading and write-1-clearing the edge-capture register, applies per-button hold-off debounce, and pushes timestamped button events into a small FIFO for downstream logic. It sits between the pushbutton PIO and fabric logic that consumes button presses without a CPU.

## Interface
- `DEPTH`, 4: event FIFO depth; power of 2, at least 2.
- `HOLDOFF`, 50000: cycles a button is suppressed after it is reported; 0 disables hold-off.
- `STAMP_W`, 16: timestamp counter width.
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `cfg_enable` in 1: level; 1 = service PIO, 0 = mask PIO and idle.
- `cfg_mask` in 4: buttons to enable in the PIO irq mask.
- `m_address` out 2: PIO register address (0 data, 2 mask, 3 edge_capture).
- `m_chipselect` out 1: PIO select.
- `m_write_n` out 1: active-low write.
- `m_writedata` out 32: write data; bits [31:4] always 0.
- `m_readdata` in 32: PIO read data; fixed read latency 1; only [3:0] used.
- `pio_irq` in 1: PIO interrupt, level.
- `evt_valid` out 1: FIFO head valid.
- `evt_ready` in 1: consumer accepts head.
- `evt_data` out STAMP_W+4: {stamp, buttons[3:0]}.
- `ovf` out 1: sticky, set when an event is dropped on full FIFO.
- `ovf_clr` in 1: clears `ovf`. Set wins on the same cycle.

## Operation
- FSM states: IDLE, WR_MASK, WAIT_IRQ, RD_CAP, RD_WAIT, CLR, PUSH, WR_OFF. Bus outputs decode combinationally from the state register.
- IDLE: `cfg_enable`=1 → WR_MASK.
- WR_MASK: one write of addr 2, data `cfg_mask`. Latch `mask_shadow` → WAIT_IRQ.
- WAIT_IRQ: priority order:
  - `cfg_enable`=0 → WR_OFF.
  - else `cfg_mask`≠`mask_shadow` → WR_MASK.
  - else `pio_irq`=1 → RD_CAP.
- RD_CAP: read of addr 3 (chipselect=1, write_n=1) → RD_WAIT.
- RD_WAIT: sample `cap` = `m_readdata[3:0]`. Bus idle → CLR.
- CLR: write addr 3, data `cap`. Only the serviced bits are cleared; edges on other bits survive.
- PUSH:
  - `rep` = `cap` & ~`holding`.
  - If `rep`≠0 and FIFO not full: enqueue {stamp, `rep`}.
  - If `rep`≠0 and FIFO full: drop the event and set `ovf`.
  - Either way, load the hold-off counter of each `rep` bit with HOLDOFF.
  - → WAIT_IRQ.
- WR_OFF: write addr 2, data 0; `mask_shadow` ← 0 → IDLE.
- Idle bus (all states not listed above): `m_chipselect`=0, `m_write_n`=1, `m_address`=0, `m_writedata`=0.
- Hold-off: 4 independent down-counters, each saturating at 0. `holding[i]` = counter≠0. Bits captured while holding are still cleared in the PIO but are not reported.
- Stamp: free-running STAMP_W counter, wraps modulo 2^STAMP_W, sampled in PUSH.
- FIFO: push/pop on the same cycle while full is allowed. While empty, a push is visible the next cycle; there is no fall-through.
- Disable mid-service: `cfg_enable` is evaluated only in WAIT_IRQ, so an in-progress service always completes.
- An edge on a bit in the same cycle as its CLR write is lost, because the PIO gives clear priority. This is accepted behaviour.

## Timing
- Reset values:
  - State = IDLE; `mask_shadow`, hold-off counters, stamp, FIFO and `ovf` = 0.
  - `evt_valid`=0, `evt_data`=0, `m_chipselect`=0, `m_write_n`=1.
- Enable: `cfg_enable` high at cycle 0 → mask write at cycle 1.
- Service sequence, with `pio_irq` sampled high in WAIT_IRQ at cycle 0:
  - Read strobe at cycle 1, data sampled at the end of cycle 2.
  - Clear write at cycle 3, enqueue at the end of cycle 4.
  - `evt_valid` at cycle 5; back in WAIT_IRQ at cycle 5.
- PIO `irq` deasserts from cycle 4, so the FSM does not re-service a stale interrupt.
- Minimum back-to-back service period: 5 cycles.

## Structure
- Package `pio_button_pkg`:
  - PIO register address constants (DATA=0, MASK=2, EDGE=3).
  - State enum.
  - Event struct {stamp, buttons}.
- Sub-module `pio_evt_fifo`: synchronous FIFO, parameterised by width and depth, with registered outputs, full and empty.

## Test plan
- Enable with `cfg_mask`=4'b0101 → single write, addr 2, writedata 0x5, at cycle 1, then WAIT_IRQ with the bus idle.
- Model PIO captures button 2, `pio_irq`=1 → read addr 3, write addr 3 data 0x4, `evt_data` buttons=4'b0100, `evt_valid` exactly 5 cycles after irq.
- HOLDOFF=20: press button 0 twice 10 cycles apart → one event, and two clear writes of 0x1. A third press at cycle 40 → second event.
- DEPTH=4 with `evt_ready`=0: five events → four queued; the fifth is dropped and `ovf`=1. `ovf_clr` pulse → `ovf`=0.
- Change `cfg_mask` to 0xF while enabled → one mask write of 0xF. Drop `cfg_enable` during RD_WAIT → CLR and PUSH complete, then a mask write of 0, then IDLE.
- Assert `reset_n` low during CLR → outputs immediately return to reset values, and the FIFO is empty.
